// File: rtl/ready_seq_arbiter.sv
// Post-reset readiness sequencer with a round-robin req/gnt hold arbiter for one shared resource.
// Optional hold limit with forced release: define ARB_HOLD_TIMEOUT_EN.
module ready_seq_arbiter #(
    parameter int N_REQ         = 4,
    parameter int WARMUP_CYCLES = 2,
    parameter int MAX_HOLD      = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [N_REQ-1:0]         req,
    output logic                     ready,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     busy,
    output logic                     timeout
);

    localparam int IDW = $clog2(N_REQ);
    localparam int WCW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

    if (N_REQ < 2 || N_REQ > 16 || WARMUP_CYCLES < 1 || MAX_HOLD < 2) begin : g_param_err
        $error("ready_seq_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {WARMUP, IDLE, GRANT} state_t;

    state_t           state;
    logic [WCW-1:0]   warm_cnt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   cand;
    logic [IDW-1:0]   next_ptr;
    logic [N_REQ-1:0] eligible;
    logic             found;

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int HCW = $clog2(MAX_HOLD);
    logic [HCW-1:0]   hold_cnt;
    logic [N_REQ-1:0] masked;
    assign eligible = req & ~masked;
`else
    assign eligible = req;
    assign timeout  = 1'b0;
`endif

    assign next_ptr = (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + 1'b1;

    // First eligible requester at or above rr_ptr, wrapping to 0.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = IDW'((32'(rr_ptr) + i) % 32'(N_REQ));
            if (!found && eligible[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= WARMUP;
            warm_cnt <= '0;
            rr_ptr   <= '0;
            ready    <= 1'b0;
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
            hold_cnt <= '0;
            masked   <= '0;
            timeout  <= 1'b0;
`endif
        end else begin
`ifdef ARB_HOLD_TIMEOUT_EN
            timeout <= 1'b0;
            masked  <= masked & req;
`endif
            case (state)
                WARMUP: begin
                    if (int'(warm_cnt) == WARMUP_CYCLES - 1) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        warm_cnt <= warm_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (found) begin
                        state  <= GRANT;
                        gnt    <= {{(N_REQ-1){1'b0}}, 1'b1} << winner;
                        gnt_id <= winner;
                        busy   <= 1'b1;
`ifdef ARB_HOLD_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (!req[gnt_id]) begin
                        state  <= IDLE;
                        gnt    <= '0;
                        gnt_id <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
`ifdef ARB_HOLD_TIMEOUT_EN
                    // Forced release on the MAX_HOLD-th held cycle; mask until req drops.
                    end else if (int'(hold_cnt) == MAX_HOLD - 1) begin
                        state          <= IDLE;
                        gnt            <= '0;
                        gnt_id         <= '0;
                        busy           <= 1'b0;
                        rr_ptr         <= next_ptr;
                        timeout        <= 1'b1;
                        masked[gnt_id] <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
`endif
                    end
                end
                default: state <= WARMUP;
            endcase
        end
    end

    a_onehot_gnt: assert property (@(posedge clk) disable iff (!rstn) $onehot0(gnt));
    a_gnt_ready:  assert property (@(posedge clk) disable iff (!rstn) (gnt != '0) |-> ready);
    a_busy:       assert property (@(posedge clk) disable iff (!rstn) busy == (|gnt));
    a_gnt_id:     assert property (@(posedge clk) disable iff (!rstn)
                                   (gnt == '0) ? (gnt_id == '0) : gnt[gnt_id]);

endmodule

// File: tb/tb_ready_seq_arbiter.sv
// Randomised and directed bench for ready_seq_arbiter against a cycle-level behavioural model.
// Hold-timeout scenario runs only when ARB_HOLD_TIMEOUT_EN is defined.
module tb_ready_seq_arbiter;

    localparam int N   = 4;
    localparam int W   = 2;
    localparam int MH  = 16;
    localparam int IDW = $clog2(N);

    logic           clk;
    logic           rstn;
    logic [N-1:0]   req;
    logic           ready;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           timeout;

    ready_seq_arbiter #(.N_REQ(N), .WARMUP_CYCLES(W), .MAX_HOLD(MH)) dut (
        .clk(clk), .rstn(rstn), .req(req), .ready(ready), .gnt(gnt),
        .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: who owns the resource, whose turn is next, warm-up progress.
    bit         m_ready;
    int         m_owner;
    int         m_ptr;
    int         m_warm;
    int         m_hold;
    bit [N-1:0] m_mask;
    bit         m_timeout;

    logic [N+IDW+2:0] act;
    assign act = {ready, busy, timeout, gnt_id, gnt};

    task automatic model_reset();
        m_ready = 0; m_owner = -1; m_ptr = 0; m_warm = 0; m_hold = 0;
        m_mask = '0; m_timeout = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] rs);
        int c;
        m_timeout = 0;
        if (!m_ready) begin
            m_warm++;
            if (m_warm >= W) m_ready = 1;
            return;
        end
        for (int i = 0; i < N; i++) if (!rs[i]) m_mask[i] = 0;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (rs[c] && !m_mask[c]) begin
                    m_owner = c;
                    m_hold  = 1;
                    break;
                end
            end
        end else if (!rs[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else begin
`ifdef ARB_HOLD_TIMEOUT_EN
            if (m_hold == MH) begin
                m_timeout        = 1;
                m_mask[m_owner]  = 1;
                m_ptr            = (m_owner + 1) % N;
                m_owner          = -1;
            end else
`endif
            m_hold++;
        end
    endtask

    function automatic logic [N+IDW+2:0] exp_vec();
        logic [N-1:0]   g;
        logic [IDW-1:0] id;
        g  = '0;
        id = '0;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            id         = IDW'(m_owner);
        end
        return {m_ready, m_owner >= 0, m_timeout, id, g};
    endfunction

    task automatic step();
        logic [N-1:0] rs;
        rs = req;
        @(posedge clk);
        if (rstn) model_edge(rs);
        #1;
    endtask

    task automatic reset_and_warm();
        rstn = 1'b0;
        model_reset();
        step();
        rstn = 1'b1;
        repeat (W) step();
    endtask

    task automatic test_reset();
        req  = '0;
        rstn = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (act !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required %b", act, {(N+IDW+3){1'b0}});
        end
        step();
        rstn = 1'b1;
        step();
        n_checks++;
        if (ready !== 1'b0 || act !== exp_vec()) begin
            n_fail++;
            $display("FAIL ready_edge1: got %b required %b", act, exp_vec());
        end
        step();
        n_checks++;
        if (ready !== 1'b1 || gnt !== '0 || act !== exp_vec()) begin
            n_fail++;
            $display("FAIL ready_edge2: got %b required %b", act, exp_vec());
        end
    endtask

    task automatic test_rr_sequence();
        logic [N-1:0] want;
        int id;
        req = '1;
        step();
        for (int k = 0; k < 5; k++) begin
            id   = k % N;
            want = '0;
            want[id] = 1'b1;
            n_checks++;
            if (gnt !== want || act !== exp_vec()) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got gnt=%b act=%b required gnt=%b act=%b", k, gnt, act, want, exp_vec());
            end
            req[id] = 1'b0;
            step();
            n_checks++;
            if (gnt !== '0 || busy !== 1'b0 || act !== exp_vec()) begin
                n_fail++;
                $display("FAIL rr_idle_gap%0d: got %b required %b", k, act, exp_vec());
            end
            req[id] = 1'b1;
            step();
        end
        req = '0;
        repeat (2) step();
    endtask

    task automatic test_warmup_req();
        req  = 4'b0100;
        rstn = 1'b0;
        model_reset();
        step();
        rstn = 1'b1;
        step();
        n_checks++;
        if (gnt !== '0 || ready !== 1'b0 || act !== exp_vec()) begin
            n_fail++;
            $display("FAIL warmup_edge1: got %b required %b", act, exp_vec());
        end
        step();
        n_checks++;
        if (gnt !== '0 || ready !== 1'b1 || act !== exp_vec()) begin
            n_fail++;
            $display("FAIL warmup_edge2: got %b required %b", act, exp_vec());
        end
        step();
        n_checks++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2 || act !== exp_vec()) begin
            n_fail++;
            $display("FAIL warmup_first_grant: got %b required %b", act, exp_vec());
        end
        req = '0;
        step();
    endtask

    task automatic test_async_reset();
        reset_and_warm();
        req = 4'b0010;
        step();
        n_checks++;
        if (gnt !== 4'b0010 || act !== exp_vec()) begin
            n_fail++;
            $display("FAIL async_pre_grant: got %b required %b", act, exp_vec());
        end
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if (gnt !== '0 || ready !== 1'b0 || busy !== 1'b0 || act !== '0) begin
            n_fail++;
            $display("FAIL async_drop: got %b required %b", act, {(N+IDW+3){1'b0}});
        end
        model_reset();
        step();
        rstn = 1'b1;
        req  = '1;
        repeat (W) step();
        step();
        n_checks++;
        if (gnt !== 4'b0001 || gnt_id !== '0 || act !== exp_vec()) begin
            n_fail++;
            $display("FAIL async_ptr_cleared: got %b required %b", act, exp_vec());
        end
        req = '0;
        repeat (2) step();
    endtask

    task automatic test_random();
        reset_and_warm();
        req = N'($urandom);
        for (int c = 0; c < 1500; c++) begin
            step();
            n_checks++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_c%0d: req=%b got %b required %b", c, req, act, exp_vec());
            end
            for (int i = 0; i < N; i++)
                if ($urandom_range(3) == 0) req[i] = ~req[i];
        end
        req = '0;
        repeat (2) step();
    endtask

`ifdef ARB_HOLD_TIMEOUT_EN
    task automatic test_timeout();
        int held1;
        int pulses;
        bit saw3;
        held1 = 0; pulses = 0; saw3 = 0;
        reset_and_warm();
        req = 4'b1010;
        for (int c = 0; c < 24; c++) begin
            if (c == 20) req[1] = 1'b0;
            step();
            if (gnt[1]) held1++;
            if (timeout) pulses++;
            if (gnt[3] && pulses > 0) saw3 = 1;
            n_checks++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("FAIL timeout_c%0d: got %b required %b", c, act, exp_vec());
            end
        end
        n_checks++;
        if (held1 != MH || pulses != 1 || !saw3) begin
            n_fail++;
            $display("FAIL timeout_summary: held=%0d pulses=%0d saw3=%0d required %0d 1 1", held1, pulses, saw3, MH);
        end
        req = '0;
        repeat (2) step();
    endtask
`endif

    initial begin
        req  = '0;
        rstn = 1'b0;
        model_reset();
        test_reset();
        test_rr_sequence();
        test_warmup_req();
        test_async_reset();
        test_random();
`ifdef ARB_HOLD_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
